// File: rtl/cache_pkg.sv
// Shared cache-controller definitions: field widths, FSM state encoding and
// the memory address composition helper.
package cache_pkg;

  localparam int unsigned TAG_W   = 8;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned LINE_W  = 32;
  localparam int unsigned MADDR_W = TAG_W + IDX_W;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WBACK = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Line address in memory is the tag in the upper bits, index in the lower.
  function automatic logic [MADDR_W-1:0] mk_addr(input logic [TAG_W-1:0] tag,
                                                 input logic [IDX_W-1:0] idx);
    return {tag, idx};
  endfunction

endpackage

// File: rtl/miss_ctrl_if.sv
// Memory-side bus of the miss controller: single strobe/ack handshake with a
// write-enable, line address and data in both directions.
interface miss_ctrl_if import cache_pkg::*; ();

  logic               memory_stb;
  logic               memory_we;
  logic [MADDR_W-1:0] memory_addr;
  logic [LINE_W-1:0]  memory_din;
  logic [LINE_W-1:0]  memory_dout;
  logic               memory_ack;

  modport master (
    output memory_stb, memory_we, memory_addr, memory_din,
    input  memory_dout, memory_ack
  );

  modport slave (
    input  memory_stb, memory_we, memory_addr, memory_din,
    output memory_dout, memory_ack
  );

endinterface

// File: rtl/miss_ctrl.sv
// Cache miss controller: optionally writes back a dirty victim line, reads the
// requested line from memory, then issues a one-cycle fill strobe to the cache.
// Keeps wrap-around miss and write-back statistics.
module miss_ctrl import cache_pkg::*; (
  input  logic               clk,
  input  logic               rst,

  input  logic               miss_req,
  input  logic               miss_dirty,
  input  logic [TAG_W-1:0]   miss_tag,
  input  logic [IDX_W-1:0]   miss_index,
  input  logic [TAG_W-1:0]   victim_tag,
  input  logic [LINE_W-1:0]  victim_data,

  output logic               fill_we,
  output logic [IDX_W-1:0]   fill_index,
  output logic [TAG_W-1:0]   fill_tag,
  output logic [LINE_W-1:0]  fill_data,
  output logic               miss_done,
  output logic               busy,

  miss_ctrl_if.master        mem,

  input  logic               stats_clr,
  output logic [CNT_W-1:0]   miss_count,
  output logic [CNT_W-1:0]   wb_count
);

  state_t state, state_n;

  logic               capture;
  logic               wb_ack;
  logic               fill_ack;
  logic               ack_v;

  logic               stb_q;
  logic               we_q;
  logic [MADDR_W-1:0] addr_q, addr_n;
  logic [LINE_W-1:0]  din_q,  din_n;

  logic [TAG_W-1:0]   lat_tag;
  logic [IDX_W-1:0]   lat_index;

  // An ack only counts while a request is actually on the bus.
  assign ack_v = mem.memory_ack & stb_q;

  assign mem.memory_stb  = stb_q;
  assign mem.memory_we   = we_q;
  assign mem.memory_addr = addr_q;
  assign mem.memory_din  = din_q;

  assign fill_tag   = lat_tag;
  assign fill_index = lat_index;
  assign busy       = (state != ST_IDLE);

  // Next-state decode; flags the capture and ack events used by the datapath.
  always_comb begin
    state_n  = state;
    capture  = 1'b0;
    wb_ack   = 1'b0;
    fill_ack = 1'b0;
    case (state)
      ST_IDLE: begin
        if (miss_req) begin
          capture = 1'b1;
          state_n = miss_dirty ? ST_WBACK : ST_FILL;
        end
      end
      ST_WBACK: begin
        if (ack_v) begin
          wb_ack  = 1'b1;
          state_n = ST_FILL;
        end
      end
      ST_FILL: begin
        if (ack_v) begin
          fill_ack = 1'b1;
          state_n  = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Bus address/data only change on transaction boundaries, so they stay
  // stable for the whole strobe. The victim tag and data are held directly in
  // the address/data registers rather than in separate latches.
  always_comb begin
    addr_n = addr_q;
    din_n  = din_q;
    if (capture) begin
      if (miss_dirty) begin
        addr_n = mk_addr(victim_tag, miss_index);
        din_n  = victim_data;
      end else begin
        addr_n = mk_addr(miss_tag, miss_index);
      end
    end else if (wb_ack) begin
      addr_n = mk_addr(lat_tag, lat_index);
    end
  end

  // State register plus registered bus and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      fill_we   <= 1'b0;
      miss_done <= 1'b0;
    end else begin
      state     <= state_n;
      stb_q     <= (state_n == ST_WBACK) || (state_n == ST_FILL);
      we_q      <= (state_n == ST_WBACK);
      addr_q    <= addr_n;
      din_q     <= din_n;
      fill_we   <= (state_n == ST_DONE);
      miss_done <= (state_n == ST_DONE);
    end
  end

  // Request capture and returned line data.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_tag   <= '0;
      lat_index <= '0;
      fill_data <= '0;
    end else begin
      if (capture) begin
        lat_tag   <= miss_tag;
        lat_index <= miss_index;
      end
      if (fill_ack) begin
        fill_data <= mem.memory_dout;
      end
    end
  end

  // Statistics counters; a clear takes priority over a same-edge increment.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      miss_count <= '0;
      wb_count   <= '0;
    end else if (capture) begin
      miss_count <= miss_count + 16'd1;
      if (miss_dirty) begin
        wb_count <= wb_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/miss_ctrl.md
MISS_CTRL -- requirements
Module: miss_ctrl

Interface
REQ-001 SHALL have: clk  in  1  clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: miss_req  in  1  cache miss pending, held high by cache until miss_done.
REQ-004 SHALL have: miss_dirty  in  1  victim line dirty, valid with miss_req.
REQ-005 SHALL have: miss_tag  in  8  requested tag.
REQ-006 SHALL have: miss_index  in  6  line index.
REQ-007 SHALL have: victim_tag  in  8  tag of the line being replaced.
REQ-008 SHALL have: victim_data  in  32  data of the line being replaced.
REQ-009 SHALL have: fill_we  out  1  one-cycle line write strobe to cache.
REQ-010 SHALL have: fill_index / fill_tag / fill_data  out  6 / 8 / 32  line write contents.
REQ-011 SHALL have: miss_done  out  1  one-cycle completion pulse, coincident with fill_we.
REQ-012 SHALL have: busy  out  1  high whenever state != IDLE.
REQ-013 SHALL have: memory_stb, memory_we  out  1 each; memory_addr  out  14; memory_din  out  32; memory_dout  in  32; memory_ack  in  1.
REQ-014 SHALL have: stats_clr  in  1; miss_count, wb_count  out  16 each.

Function
REQ-015 SHALL implement states IDLE, WBACK, FILL, DONE.
REQ-016 In IDLE with miss_req=1, SHALL latch miss_tag, miss_index, victim_tag, victim_data on that edge; next state WBACK if miss_dirty=1, else FILL.
REQ-017 WBACK: memory_stb=1, memory_we=1, memory_addr={victim_tag,index}, memory_din=latched victim_data; on edge with memory_ack=1 -> FILL.
REQ-018 FILL: memory_stb=1, memory_we=0, memory_addr={miss_tag,index}; on edge with memory_ack=1 latch memory_dout into fill_data, -> DONE.
REQ-019 DONE: fill_we=1, miss_done=1, fill_index/fill_tag = latched values, for exactly one cycle; -> IDLE.
REQ-020 memory_stb, memory_we, memory_addr, memory_din SHALL be registered and stable for the whole transaction until ack; stb=0 in the cycle after ack edge (or state change).
REQ-021 memory_ack while memory_stb=0 SHALL be ignored.
REQ-022 Latency: clean miss, ack on k-th stb cycle -> miss_done k+1 cycles after capture edge; dirty miss, acks after k1, k2 stb cycles -> k1+k2+1.
REQ-023 Requester SHALL drop miss_req on the edge miss_done is sampled; IDLE following DONE SHALL see miss_req=0 (back-to-back misses start no earlier than one cycle after DONE).
REQ-024 Input changes on miss_* while busy SHALL have no effect.
REQ-025 miss_count SHALL increment on IDLE->(WBACK|FILL); wb_count SHALL increment on IDLE->WBACK; both wrap 16'hFFFF -> 0.
REQ-026 stats_clr=1 SHALL zero both counters on that edge; clr wins over simultaneous increment.

Reset
REQ-027 rst=1 SHALL force state IDLE, memory_stb=0, memory_we=0, fill_we=0, miss_done=0, busy=0, counters=0, memory_addr=0, memory_din=0, fill_* = 0, from next edge.
REQ-028 rst mid-transaction SHALL abandon it; no fill_we/miss_done emitted; a late memory_ack after reset ignored.

Structure
REQ-029 State encoding, TAG_W=8, IDX_W=6, LINE_W=32, MADDR_W=14 SHALL reside in shared package cache_pkg.
REQ-030 Single module; no sub-module required (counters inline).

Verification
REQ-031 Clean miss tag=8'h12 idx=6'h05, ack on 3rd stb cycle, dout=32'hDEADBEEF -> one read at addr 14'h0485, fill_data=32'hDEADBEEF, miss_done 4 cycles after capture, miss_count=1, wb_count=0.
REQ-032 Dirty miss victim_tag=8'hA0 data=32'h01020304, tag=8'h12 idx=6'h05 -> write addr 14'h2805 din 32'h01020304, then read 14'h0485, miss_count=1, wb_count=1.
REQ-033 Reset asserted during FILL stb -> stb=0 next cycle, no miss_done, state IDLE, counters 0.
REQ-034 Counters preset to 16'hFFFF via 65535 misses (or force) then one miss -> miss_count=0; stats_clr coincident with increment -> 0.
REQ-035 Spurious memory_ack in IDLE and miss_* toggling during FILL -> no state change, fill_tag/index equal captured values.
REQ-036 Two back-to-back misses (miss_req re-asserted one cycle after DONE) -> two independent transactions, miss_count=2.
